sram_req_ctrl: RTL and testbench

SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

---
 rtl/sram_req_ctrl.sv | 143 ++++++++++++++
 tb/tb_sram_req_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// Purpose: valid/ready request front-end for a single-port synchronous SRAM with an in-order read response FIFO.
// Latency: request reaches the SRAM in the accept cycle; read data appears on rsp_valid/rsp_rdata one cycle later.
// Backpressure: req_ready drops once queued plus in-flight reads reach 3; rsp_ready never feeds req_ready combinationally.
//
// Ports:
//   clk, rst                       single rising-edge clock, synchronous active-high reset
//   req_valid/req_ready            request handshake; req_wr, req_be, req_addr, req_wdata qualify it
//   rsp_valid/rsp_ready, rsp_rdata read response handshake and data
//   init_busy                      power-up zero sweep in progress
//   sram_csn/wen/web/addr/din      active-low SRAM strobes, address and write data
//   sram_dout                      SRAM read data, valid the cycle after a read strobe
// Build option: define SRAM_REQ_CTRL_INIT_EN to zero the whole array after every reset.
module sram_req_ctrl #(
  parameter int N_DW = 32,
  parameter int N_DP = 512,
  parameter int N_DM = N_DW / 8,
  parameter int N_AW = (N_DP == 1) ? 1 : $clog2(N_DP)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [N_DM-1:0] req_be,
  input  logic [N_AW-1:0] req_addr,
  input  logic [N_DW-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [N_DW-1:0] rsp_rdata,
  output logic            init_busy,
  output logic            sram_csn,
  output logic            sram_wen,
  output logic [N_DM-1:0] sram_web,
  output logic [N_AW-1:0] sram_addr,
  output logic [N_DW-1:0] sram_din,
  input  logic [N_DW-1:0] sram_dout
);

  // Response FIFO: 3 entries, circular pointers wrapping at 2.
  logic [N_DW-1:0] fifo_mem [3];
  logic [1:0]      fifo_cnt;
  logic [1:0]      rd_ptr;
  logic [1:0]      wr_ptr;
  logic            inflight;
  logic            fifo_empty;
  logic [2:0]      occupancy;
  logic            accept;
  logic            accept_rd;
  logic            store;
  logic            deq;
  logic            init_wr;
  logic [N_AW-1:0] init_addr;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

`ifdef SRAM_REQ_CTRL_INIT_EN
  localparam logic [N_AW-1:0] INIT_LAST = N_AW'(N_DP - 1);
  logic init_q;

  // Sweep restarts from address 0 on every reset, including mid-sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_q    <= 1'b1;
      init_addr <= '0;
    end else if (init_q) begin
      if (init_addr == INIT_LAST) init_q <= 1'b0;
      else                        init_addr <= init_addr + N_AW'(1);
    end
  end

  assign init_busy = init_q;
  assign init_wr   = init_q && !rst;
`else
  assign init_busy = 1'b0;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif

  assign fifo_empty = (fifo_cnt == 2'd0);
  // Counting the in-flight read reserves its FIFO slot before the data arrives.
  assign occupancy  = {1'b0, fifo_cnt} + {2'b00, inflight};
  assign req_ready  = !rst && !init_busy && (occupancy < 3'd3);
  assign accept     = req_valid && req_ready;
  assign accept_rd  = accept && !req_wr;

  // SRAM drive: init sweep has priority; otherwise the accepted request passes straight through.
  always_comb begin
    sram_csn  = 1'b1;
    sram_wen  = 1'b1;
    sram_web  = '1;
    sram_addr = req_addr;
    sram_din  = req_wdata;
    if (rst) begin
      sram_addr = '0;
      sram_din  = '0;
    end else if (init_wr) begin
      sram_csn  = 1'b0;
      sram_wen  = 1'b0;
      sram_web  = '0;
      sram_addr = init_addr;
      sram_din  = '0;
    end else if (accept) begin
      sram_csn = 1'b0;
      sram_wen = ~req_wr;
      sram_web = req_wr ? ~req_be : '1;
    end
  end

  // Empty FIFO with returning data falls through to the output, so a read shows up
  // one cycle after acceptance and is only stored if the consumer stalls.
  assign rsp_valid = !rst && (!fifo_empty || inflight);
  assign rsp_rdata = rst         ? '0 :
                     !fifo_empty ? fifo_mem[rd_ptr] :
                     inflight    ? sram_dout : '0;

  assign store = inflight && !(fifo_empty && rsp_ready);
  assign deq   = !fifo_empty && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      fifo_cnt <= 2'd0;
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
    end else begin
      inflight <= accept_rd;
      if (store) wr_ptr <= ptr_inc(wr_ptr);
      if (deq)   rd_ptr <= ptr_inc(rd_ptr);
      case ({store, deq})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && store) fifo_mem[wr_ptr] <= sram_dout;
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural single-port SRAM (N_DP=16).
module tb_sram_req_ctrl;
  localparam int DW = 32;
  localparam int DP = 16;
  localparam int DM = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_wr;
  logic [DM-1:0] req_be;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_busy;
  logic          sram_csn, sram_wen;
  logic [DM-1:0] sram_web;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  int n_checks = 0;
  int n_fail   = 0;
  int acc;

  always #5 clk = ~clk;

  sram_req_ctrl #(.N_DW(DW), .N_DP(DP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_busy(init_busy),
    .sram_csn(sram_csn), .sram_wen(sram_wen), .sram_web(sram_web),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // SRAM model: filled with a marker pattern during reset so zero-init is observable.
  logic [DW-1:0] mem_m [DP];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DP; i++) mem_m[i] <= 32'hDEAD_BEEF;
    end else if (!sram_csn) begin
      if (!sram_wen) begin
        for (int b = 0; b < DM; b++)
          if (!sram_web[b]) mem_m[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= mem_m[sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_be = 4'hF;
    req_addr = 4'd3; req_wdata = 32'h0000_0123; rsp_ready = 1'b0;

    // Reset state, with a request offered that must be ignored.
    @(negedge clk); #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_csn", sram_csn, 1);
    chk("rst_wen", sram_wen, 1);
    chk("rst_web", sram_web, 4'hF);
    chk("rst_addr", sram_addr, 0);
    chk("rst_din", sram_din, 0);
    chk("rst_rdata", rsp_rdata, 0);

    @(negedge clk); rst = 1'b0; req_valid = 1'b0; #1;
`ifdef SRAM_REQ_CTRL_INIT_EN
    chk("init_busy0", init_busy, 1);
    chk("init_ready0", req_ready, 0);
    chk("init_addr0", sram_addr, 0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #1;
      chk("init_addr_pre", sram_addr, 64'(i));
    end
    // Reset mid-sweep: sweep must restart at address 0.
    @(negedge clk); rst = 1'b1; #1;
    chk("init_rst_csn", sram_csn, 1);
    @(negedge clk); rst = 1'b0; #1;
    for (int i = 0; i < DP; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk("init_busy", init_busy, 1);
      chk("init_ready", req_ready, 0);
      chk("init_csn", sram_csn, 0);
      chk("init_wen", sram_wen, 0);
      chk("init_web", sram_web, 0);
      chk("init_addr", sram_addr, 64'(i));
      chk("init_din", sram_din, 0);
    end
    @(negedge clk); #1;
    chk("init_done", init_busy, 0);
    chk("init_done_ready", req_ready, 1);
    @(negedge clk); req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd9; rsp_ready = 1'b1; #1;
    chk("init_rd_accept", req_ready, 1);
    @(negedge clk); req_valid = 1'b0; #1;
    chk("init_rd_valid", rsp_valid, 1);
    chk("init_rd_data", rsp_rdata, 0);
`else
    chk("noinit_busy", init_busy, 0);
    chk("noinit_ready", req_ready, 1);
    chk("idle_csn", sram_csn, 1);
`endif

    // Full write then read-after-write to the same address.
    @(negedge clk); rsp_ready = 1'b1;
    req_valid = 1'b1; req_wr = 1'b1; req_be = 4'hF; req_addr = 4'd5; req_wdata = 32'hA5A5_1234; #1;
    chk("wr_ready", req_ready, 1);
    chk("wr_csn", sram_csn, 0);
    chk("wr_wen", sram_wen, 0);
    chk("wr_web", sram_web, 4'h0);
    chk("wr_addr", sram_addr, 5);
    chk("wr_din", sram_din, 32'hA5A5_1234);
    @(negedge clk); req_wr = 1'b0; #1;
    chk("rd_wen", sram_wen, 1);
    chk("rd_web", sram_web, 4'hF);
    chk("rd_no_rsp_after_wr", rsp_valid, 0);
    @(negedge clk); req_valid = 1'b0; #1;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_rdata, 32'hA5A5_1234);
    @(negedge clk); #1;
    chk("rd_rsp_drained", rsp_valid, 0);
    chk("idle_csn2", sram_csn, 1);

    // Partial byte write into a zeroed word, then a be=0 write that must change nothing.
    @(negedge clk); req_valid = 1'b1; req_wr = 1'b1; req_be = 4'hF; req_addr = 4'd2; req_wdata = 32'h0; #1;
    @(negedge clk); req_be = 4'h2; req_wdata = 32'hFFFF_FFFF; #1;
    chk("be2_web", sram_web, 4'hD);
    @(negedge clk); req_be = 4'h0; req_wdata = 32'h1234_5678; #1;
    chk("be0_csn", sram_csn, 0);
    chk("be0_web", sram_web, 4'hF);
    @(negedge clk); req_wr = 1'b0; #1;
    chk("be0_no_rsp", rsp_valid, 0);
    @(negedge clk); req_valid = 1'b0; #1;
    chk("be2_data", rsp_rdata, 32'h0000_FF00);
    chk("be2_valid", rsp_valid, 1);

    // Preload 0..7, then 8 back-to-back reads with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); req_valid = 1'b1; req_wr = 1'b1; req_be = 4'hF;
      req_addr = AW'(i); req_wdata = 32'h1000 + 32'(i); #1;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); req_wr = 1'b0; req_addr = AW'(k); #1;
      chk("b2b_ready", req_ready, 1);
      chk("b2b_valid", rsp_valid, 64'(k > 0));
      if (k > 0) chk("b2b_data", rsp_rdata, 32'h1000 + 32'(k - 1));
    end
    @(negedge clk); req_valid = 1'b0; #1;
    chk("b2b_last_data", rsp_rdata, 32'h1007);
    @(negedge clk); #1;
    chk("b2b_drained", rsp_valid, 0);

    // Stalled consumer with continuous reads: three accepted, output held.
    acc = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); req_valid = 1'b1; req_wr = 1'b0; req_addr = AW'(acc); #1;
      chk("stall_ready", req_ready, 64'(i < 3));
      chk("stall_csn", sram_csn, 64'(i >= 3));
      if (i >= 1) begin
        chk("stall_valid", rsp_valid, 1);
        chk("stall_data", rsp_rdata, 32'h1000);
      end
      if (req_ready) acc++;
    end
    chk("stall_accepted", acc, 3);
    @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1; #1;
    chk("drain_ready_nocomb", req_ready, 0);
    chk("drain0", rsp_rdata, 32'h1000);
    @(negedge clk); #1;
    chk("drain1", rsp_rdata, 32'h1001);
    @(negedge clk); #1;
    chk("drain2", rsp_rdata, 32'h1002);
    chk("drain2_valid", rsp_valid, 1);
    @(negedge clk); #1;
    chk("drain_empty", rsp_valid, 0);

    // Reset with two queued responses and one read in flight.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); req_valid = 1'b1; req_wr = 1'b0; req_addr = AW'(4 + i); #1;
      chk("pre_rst_ready", req_ready, 1);
    end
    @(negedge clk); req_valid = 1'b0; rst = 1'b1; #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_csn", sram_csn, 1);
    chk("mid_rst_rdata", rsp_rdata, 0);
    @(negedge clk); rst = 1'b0; rsp_ready = 1'b1; #1;
    chk("post_rst_valid", rsp_valid, 0);
`ifdef SRAM_REQ_CTRL_INIT_EN
    chk("post_rst_busy", init_busy, 1);
    chk("post_rst_addr", sram_addr, 0);
    for (int i = 1; i < DP; i++) begin
      @(negedge clk); #1;
      chk("post_rst_sweep_valid", rsp_valid, 0);
    end
    @(negedge clk); #1;
    chk("post_rst_busy_done", init_busy, 0);
`else
    chk("post_rst_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("post_rst_no_stale", rsp_valid, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
